cla_shared_add_sched: RTL and testbench

Scheduler that shares a single 4-bit generate/propagate carry-lookahead adder slice between two requesters. Each requester submits a WIDTH-bit add job. The block picks one job by round-robin, then sequences it through the slice one nibble per cycle, LSB nibble first, keeping the carry in a register. It returns the result over a valid/ready response channel tagged with the requester ID. It sits between the arithmetic clients and the shared nibble adder, so the design needs only one lookahead slice.

---
 rtl/cla_shared_add_sched.sv | 170 +++++++++++++++++
 tb/tb_cla_shared_add_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_shared_add_sched.sv
// cla_shared_add_sched
//
// Shares one 4-bit generate/propagate carry-lookahead slice between two
// requesters. A round-robin arbiter picks one WIDTH-bit add job. The job
// then runs through the slice one nibble per cycle, LSB nibble first, with
// the inter-nibble carry held in a register. The result is returned on a
// valid/ready channel, tagged with the owning requester.
//
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready     job handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin    job operands, sampled only at the handshake
//   rsp_valid / rsp_ready       result handshake
//   rsp_sum, rsp_cout           (a+b+cin) mod 2^WIDTH and its carry-out
//   rsp_id                      requester that owns the result
//   busy                        a job is in flight (ADD or DONE)
//
// Timing: a job accepted in cycle 0 presents rsp_valid in cycle NIB+1.
// With rsp_ready held high, the block is occupied for NIB+2 cycles per job.

module cla_shared_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  // Keep the nibble index at least one bit wide so WIDTH=4 still elaborates.
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic             last_served_q;

  // ---------------------------------------------------------------------------
  // Arbitration. A requester wins outright when it is alone. On a tie, the
  // winner is the requester that was not served last. The readies depend only
  // on the valids and the state, so a requester may hold valid without looking
  // at ready.
  // ---------------------------------------------------------------------------
  logic grant0, grant1, accept_ok;

  assign grant0    = req0_valid & (~req1_valid |  last_served_q);
  assign grant1    = req1_valid & (~req0_valid | ~last_served_q);
  // NOTE: rst gates the readies combinationally. A requester must not see a
  // handshake in a cycle where the synchronous reset will discard the job.
  assign accept_ok  = (state_q == IDLE) & ~rst;
  assign req0_ready = accept_ok & grant0;
  assign req1_ready = accept_ok & grant1;

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Shared 4-bit lookahead slice. The carries are written as flattened
  // lookahead equations, so no carry depends on another carry.
  // ---------------------------------------------------------------------------
  logic [3:0] nib_a, nib_b, g, p, c, nib_sum;
  logic       nib_cout;

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];
  assign g     = nib_a & nib_b;
  assign p     = nib_a ^ nib_b;

  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & carry_q);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
  assign nib_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & carry_q);
  assign nib_sum = p ^ c;

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0_ready | req1_ready) state_d = ADD;
      ADD:     if (idx_q == LAST_IDX)       state_d = DONE;
      DONE:    if (rsp_ready)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, nibble sequencing, result assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      carry_q       <= 1'b0;
      idx_q         <= '0;
      last_served_q <= 1'b1;   // requester 0 wins the first tie
      rsp_sum       <= '0;
      rsp_cout      <= 1'b0;
      rsp_id        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_ready) begin
            a_q           <= req0_a;
            b_q           <= req0_b;
            carry_q       <= req0_cin;
            idx_q         <= '0;
            rsp_sum       <= '0;
            rsp_cout      <= 1'b0;
            rsp_id        <= 1'b0;
            last_served_q <= 1'b0;
          end else if (req1_ready) begin
            a_q           <= req1_a;
            b_q           <= req1_b;
            carry_q       <= req1_cin;
            idx_q         <= '0;
            rsp_sum       <= '0;
            rsp_cout      <= 1'b0;
            rsp_id        <= 1'b1;
            last_served_q <= 1'b1;
          end
        end
        ADD: begin
          rsp_sum[{idx_q, 2'b00} +: 4] <= nib_sum;
          carry_q                      <= nib_cout;
          idx_q                        <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) rsp_cout <= nib_cout;
        end
        default: ;   // DONE: the result is held until the response handshake
      endcase
    end
  end

endmodule

// File: tb/tb_cla_shared_add_sched.sv
// Directed testbench for cla_shared_add_sched. A WIDTH=16 instance and a
// WIDTH=4 instance share the clock and reset. Inputs are driven 1 ns after the
// rising edge and outputs are compared 2 ns after it.

module tb_cla_shared_add_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_sum;

  logic       q0_valid, q0_ready, q0_cin, q1_valid, q1_ready, q1_cin;
  logic [3:0] q0_a, q0_b, q1_a, q1_b, q_sum;
  logic       q_valid, q_ready, q_cout, q_id, q_busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cla_shared_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  cla_shared_add_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(q0_valid), .req0_ready(q0_ready),
    .req0_a(q0_a), .req0_b(q0_b), .req0_cin(q0_cin),
    .req1_valid(q1_valid), .req1_ready(q1_ready),
    .req1_a(q1_a), .req1_b(q1_b), .req1_cin(q1_cin),
    .rsp_valid(q_valid), .rsp_ready(q_ready), .rsp_sum(q_sum),
    .rsp_cout(q_cout), .rsp_id(q_id), .busy(q_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Call at +1 ns of cycle 1 after an accept. Returns the cycle number (counted
  // from the accept cycle) in which rsp_valid is first seen, or 20 on timeout.
  task automatic wait_rsp(input string tag, output int cyc);
    cyc = 1;
    #1;
    while (!rsp_valid && cyc < 20) begin
      check({tag, ".busy_add"}, busy, 1);
      next_cycle();
      #1;
      cyc++;
    end
  endtask

  // One job from requester id with rsp_ready held high.
  task automatic run_job(input string tag, input bit id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
    int cyc;
    if (!id) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin;
    end
    rsp_ready = 1;
    #1;
    check({tag, ".ready"},       id ? req1_ready : req0_ready, 1);
    check({tag, ".other_ready"}, id ? req0_ready : req1_ready, 0);
    next_cycle();
    // Drop valid and scramble the operands: the captured job must be unaffected.
    req0_valid = 0; req1_valid = 0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    wait_rsp(tag, cyc);
    check({tag, ".latency"}, cyc, 5);
    check({tag, ".busy_done"}, busy, 1);
    check({tag, ".sum"},  rsp_sum, exp_sum);
    check({tag, ".cout"}, rsp_cout, exp_cout);
    check({tag, ".id"},   rsp_id, id);
    next_cycle();
    #1;
    check({tag, ".valid_drop"}, rsp_valid, 0);
    check({tag, ".busy_idle"},  busy, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    req0_valid = 1;   // readies must stay low while rst is high
    req1_valid = 0;
    #1;
    check("reset.req0_ready", req0_ready, 0);
    next_cycle();
    next_cycle();
    req0_valid = 0;
    rst = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       gorder [3];
    logic       rid    [3];
    logic [W-1:0] rsum [3];
    logic       rcout  [3];
    int         ng, nr, cyc;
    logic       seen;

    rst = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    rsp_ready  = 1;
    q0_valid = 0; q0_a = '0; q0_b = '0; q0_cin = 0;
    q1_valid = 0; q1_a = '0; q1_b = '0; q1_cin = 0;
    q_ready  = 1;

    next_cycle();
    do_reset();
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.busy",      busy, 0);
    check("reset.rsp_sum",   rsp_sum, 0);
    check("reset.rsp_cout",  rsp_cout, 0);
    check("reset.rsp_id",    rsp_id, 0);

    // 1. basic add, requester 0
    next_cycle();
    run_job("t1", 0, 16'h1234, 16'h4321, 0, 16'h5555, 0);

    // 2. full carry ripple, requester 1
    next_cycle();
    run_job("t2a", 1, 16'hFFFF, 16'h0000, 1, 16'h0000, 1);
    next_cycle();
    run_job("t2b", 1, 16'h7FFF, 16'h0001, 1, 16'h8001, 0);

    // 3. arbitration after reset with both requesters held valid
    next_cycle();
    do_reset();
    req0_valid = 1; req0_a = 16'h8000; req0_b = 16'h8000; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h00FF; req1_b = 16'h0001; req1_cin = 0;
    rsp_ready  = 1;
    #1;
    ng = 0; nr = 0;
    for (int k = 0; k < 40 && nr < 3; k++) begin
      check("t3.one_ready", req0_ready & req1_ready, 0);
      if ((req0_ready | req1_ready) && ng < 3) begin
        gorder[ng] = req1_ready;
        ng++;
      end
      if (rsp_valid) begin
        rid[nr] = rsp_id; rsum[nr] = rsp_sum; rcout[nr] = rsp_cout;
        nr++;
      end
      if (nr < 3) begin
        next_cycle();
        #1;
      end
    end
    req0_valid = 0; req1_valid = 0;
    check("t3.grants", ng, 3);
    check("t3.responses", nr, 3);
    if (ng == 3) begin
      check("t3.grant0", gorder[0], 0);
      check("t3.grant1", gorder[1], 1);
      check("t3.grant2", gorder[2], 0);
    end
    if (nr == 3) begin
      check("t3.id0", rid[0], 0);   check("t3.sum0", rsum[0], 16'h0000);  check("t3.cout0", rcout[0], 1);
      check("t3.id1", rid[1], 1);   check("t3.sum1", rsum[1], 16'h0100);  check("t3.cout1", rcout[1], 0);
      check("t3.id2", rid[2], 0);   check("t3.sum2", rsum[2], 16'h0000);  check("t3.cout2", rcout[2], 1);
    end
    next_cycle();
    #1;
    check("t3.idle", busy, 0);

    // 4. backpressure: F000 + 1234 + 1 = 0x10235
    next_cycle();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'hF000; req0_b = 16'h1234; req0_cin = 1;
    #1;
    check("t4.req0_ready", req0_ready, 1);
    next_cycle();
    req0_valid = 0;
    wait_rsp("t4", cyc);
    check("t4.latency", cyc, 5);
    req1_valid = 1; req1_a = 16'h0001; req1_b = 16'h0001; req1_cin = 0;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("t4.hold_valid", rsp_valid, 1);
      check("t4.hold_sum",   rsp_sum, 16'h0235);
      check("t4.hold_cout",  rsp_cout, 1);
      check("t4.hold_id",    rsp_id, 0);
      check("t4.hold_r0",    req0_ready, 0);
      check("t4.hold_r1",    req1_ready, 0);
      next_cycle();
      #1;
    end
    check("t4.still_valid", rsp_valid, 1);
    rsp_ready = 1;
    next_cycle();
    #1;
    check("t4.valid_drop",  rsp_valid, 0);
    check("t4.pending_r1",  req1_ready, 1);
    check("t4.sum_kept",    rsp_sum, 16'h0235);
    check("t4.cout_kept",   rsp_cout, 1);
    next_cycle();
    req1_valid = 0;
    wait_rsp("t4b", cyc);
    check("t4b.latency", cyc, 5);
    check("t4b.sum",  rsp_sum, 16'h0002);
    check("t4b.cout", rsp_cout, 0);
    check("t4b.id",   rsp_id, 1);
    next_cycle();

    // 5. reset in the second ADD cycle aborts the job
    req0_valid = 1; req0_a = 16'h5555; req0_b = 16'h5555; req0_cin = 0;
    rsp_ready = 1;
    #1;
    check("t5.ready", req0_ready, 1);
    next_cycle();                       // cycle 1 (ADD)
    req0_valid = 0;
    next_cycle();                       // cycle 2 (ADD): reset plus a request
    rst = 1;
    req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h0001;
    #1;
    check("t5.rst_r0", req0_ready, 0);
    check("t5.rst_r1", req1_ready, 0);
    next_cycle();                       // cycle 3
    rst = 0;
    req0_valid = 0;
    #1;
    check("t5.rsp_valid", rsp_valid, 0);
    check("t5.busy",      busy, 0);
    check("t5.rsp_sum",   rsp_sum, 0);
    check("t5.rsp_cout",  rsp_cout, 0);
    check("t5.rsp_id",    rsp_id, 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | rsp_valid | busy;
      next_cycle();
      #1;
    end
    check("t5.no_response", seen, 0);
    next_cycle();
    run_job("t5b", 0, 16'h0001, 16'h0002, 0, 16'h0003, 0);

    // 6. WIDTH=4 instance: ADD lasts one cycle
    next_cycle();
    q0_valid = 1; q0_a = 4'hF; q0_b = 4'h1; q0_cin = 0;
    q_ready = 1;
    #1;
    check("t6.ready", q0_ready, 1);
    next_cycle();
    q0_valid = 0;
    #1;
    check("t6.c1_valid", q_valid, 0);
    check("t6.c1_busy",  q_busy, 1);
    next_cycle();
    #1;
    check("t6.c2_valid", q_valid, 1);
    check("t6.sum",  q_sum, 4'h0);
    check("t6.cout", q_cout, 1);
    check("t6.id",   q_id, 0);
    next_cycle();
    #1;
    check("t6.valid_drop", q_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
